// File: rtl/svm_model_loader_if.sv
// rtl/svm_model_loader_if.sv - word stream handshake between host and SVM model loader
interface svm_model_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/svm_model_loader.sv
// rtl/svm_model_loader.sv - framed stream writer for SVM support-vector/alpha memories and bias
// Optional trailer checksum state enabled by defining SVM_LOADER_CHECKSUM_EN.
module svm_model_loader #(
    parameter int              DATA_WIDTH       = 32,
    parameter int              FEATURE_SIZE     = 13,
    parameter int              MAX_SV           = 11237,
    parameter int              SV_ADDR_WIDTH    = 18,
    parameter int              ALPHA_ADDR_WIDTH = 14,
    parameter logic [31:0]     MAGIC            = 32'h53564D31
) (
    input  logic                        clk,
    input  logic                        rst,
    svm_model_loader_if.slave           s,
    output logic                        sv_we,
    output logic [SV_ADDR_WIDTH-1:0]    sv_addr,
    output logic                        alpha_we,
    output logic [ALPHA_ADDR_WIDTH-1:0] alpha_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic [DATA_WIDTH-1:0]       bias,
    output logic [15:0]                 num_sv,
    output logic                        busy,
    output logic                        model_valid,
    output logic                        error,
    output logic [1:0]                  error_code
);
    typedef enum logic [2:0] {
        IDLE, COUNT, BIAS, ALPHA, FEAT,
`ifdef SVM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERR
    } state_t;

    state_t                      state_q, state_d;
    logic                        ready_q, ready_d;
    logic                        sv_we_q, sv_we_d, alpha_we_q, alpha_we_d;
    logic [SV_ADDR_WIDTH-1:0]    sv_addr_q, sv_addr_d, sv_cnt_q, sv_cnt_d;
    logic [ALPHA_ADDR_WIDTH-1:0] alpha_addr_q, alpha_addr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d, bias_q, bias_d, bias_stage_q, bias_stage_d;
    logic [15:0]                 num_sv_q, num_sv_d, n_stage_q, n_stage_d, sv_idx_q, sv_idx_d;
    logic [7:0]                  feat_idx_q, feat_idx_d;
    logic                        busy_q, busy_d, mv_q, mv_d, error_q, error_d;
    logic [1:0]                  code_q, code_d;
    logic                        accept;
    state_t                      end_state;
`ifdef SVM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]       csum_q, csum_d;
    assign end_state = CHECK;
`else
    assign end_state = DONE;
`endif

    assign accept = s.s_valid && ready_q;

    always_comb begin
        state_d      = state_q;
        sv_we_d      = 1'b0;
        alpha_we_d   = 1'b0;
        sv_addr_d    = sv_addr_q;
        sv_cnt_d     = sv_cnt_q;
        alpha_addr_d = alpha_addr_q;
        wdata_d      = wdata_q;
        bias_d       = bias_q;
        bias_stage_d = bias_stage_q;
        num_sv_d     = num_sv_q;
        n_stage_d    = n_stage_q;
        sv_idx_d     = sv_idx_q;
        feat_idx_d   = feat_idx_q;
        busy_d       = busy_q;
        mv_d         = mv_q;
        error_d      = error_q;
        code_d       = code_q;
`ifdef SVM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        if (accept && state_q inside {BIAS, ALPHA, FEAT}) csum_d = csum_q ^ s.s_data;
`endif
        case (state_q)
            IDLE: if (accept && s.s_data == DATA_WIDTH'(MAGIC)) begin
                state_d = COUNT;
                busy_d  = 1'b1;
                mv_d    = 1'b0;
                error_d = 1'b0;
                code_d  = 2'd0;
            end
            COUNT: if (accept) begin
                if (s.s_data[23:16] != 8'(FEATURE_SIZE)) begin
                    state_d = ERR;
                    code_d  = 2'd1;
                end else if (s.s_data[15:0] == 16'd0 || s.s_data[15:0] > 16'(MAX_SV)) begin
                    state_d = ERR;
                    code_d  = 2'd2;
                end else begin
                    n_stage_d  = s.s_data[15:0];
                    sv_idx_d   = '0;
                    feat_idx_d = '0;
                    sv_cnt_d   = '0;
                    state_d    = BIAS;
                end
`ifdef SVM_LOADER_CHECKSUM_EN
                csum_d = s.s_data;
`endif
            end
            BIAS: if (accept) begin
                bias_stage_d = s.s_data;
                state_d      = ALPHA;
            end
            ALPHA: if (accept) begin
                alpha_we_d   = 1'b1;
                alpha_addr_d = sv_idx_q[ALPHA_ADDR_WIDTH-1:0];
                wdata_d      = s.s_data;
                state_d      = FEAT;
            end
            FEAT: if (accept) begin
                // Running address replaces sv_idx*FEATURE_SIZE+feat_idx
                sv_we_d   = 1'b1;
                sv_addr_d = sv_cnt_q;
                sv_cnt_d  = sv_cnt_q + 1'b1;
                wdata_d   = s.s_data;
                if (feat_idx_q == 8'(FEATURE_SIZE - 1)) begin
                    feat_idx_d = '0;
                    sv_idx_d   = sv_idx_q + 16'd1;
                    state_d    = (sv_idx_q + 16'd1 < n_stage_q) ? ALPHA : end_state;
                end else begin
                    feat_idx_d = feat_idx_q + 8'd1;
                end
            end
`ifdef SVM_LOADER_CHECKSUM_EN
            CHECK: if (accept) begin
                if (s.s_data == csum_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ERR;
                    code_d  = 2'd3;
                end
            end
`endif
            DONE: begin
                bias_d   = bias_stage_q;
                num_sv_d = n_stage_q;
                mv_d     = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = !(state_d == DONE || state_d == ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            sv_we_q      <= 1'b0;
            alpha_we_q   <= 1'b0;
            sv_addr_q    <= '0;
            sv_cnt_q     <= '0;
            alpha_addr_q <= '0;
            wdata_q      <= '0;
            bias_q       <= '0;
            bias_stage_q <= '0;
            num_sv_q     <= '0;
            n_stage_q    <= '0;
            sv_idx_q     <= '0;
            feat_idx_q   <= '0;
            busy_q       <= 1'b0;
            mv_q         <= 1'b0;
            error_q      <= 1'b0;
            code_q       <= '0;
`ifdef SVM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            sv_we_q      <= sv_we_d;
            alpha_we_q   <= alpha_we_d;
            sv_addr_q    <= sv_addr_d;
            sv_cnt_q     <= sv_cnt_d;
            alpha_addr_q <= alpha_addr_d;
            wdata_q      <= wdata_d;
            bias_q       <= bias_d;
            bias_stage_q <= bias_stage_d;
            num_sv_q     <= num_sv_d;
            n_stage_q    <= n_stage_d;
            sv_idx_q     <= sv_idx_d;
            feat_idx_q   <= feat_idx_d;
            busy_q       <= busy_d;
            mv_q         <= mv_d;
            error_q      <= error_d;
            code_q       <= code_d;
`ifdef SVM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign s.s_ready   = ready_q;
    assign sv_we       = sv_we_q;
    assign sv_addr     = sv_addr_q;
    assign alpha_we    = alpha_we_q;
    assign alpha_addr  = alpha_addr_q;
    assign mem_wdata   = wdata_q;
    assign bias        = bias_q;
    assign num_sv      = num_sv_q;
    assign busy        = busy_q;
    assign model_valid = mv_q;
    assign error       = error_q;
    assign error_code  = code_q;
endmodule
